rl_run_controller: RTL and testbench

//  Drives one range-limited (RL) force pass per MD iteration and sequences the passes. Sits above the
//  RL top and acts as the initiator that the RL top responds to.
//  Per pass: holds start high, waits for every cell's reading_done, then waits for the force pipeline
//  to drain. It then triggers motion update and advances the iteration count. A watchdog flags a hung pass.

---
 rtl/rl_run_controller.sv | 158 +++++++++++++++
 tb/tb_rl_run_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rl_run_controller.sv
// Purpose : sequences range-limited force passes for one MD run (start hold, read wait, drain, motion update).
// Latency : every transition lands on the clock edge after its condition is seen; all outputs are registered.
// Backpres: holds in READ_WAIT/DRAIN/MU until the RL top reports progress; a watchdog parks it in ERROR if stuck.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_go, i_abort                run start (IDLE only) / return to IDLE from anywhere
//   i_num_iterations             passes per run, sampled on go (0 runs one pass)
//   i_reading_done               per-cell reading finished
//   i_back_pressure              per-cell back pressure
//   i_filter_buffer_empty        per-cell filter buffers empty
//   i_force_valid_and            AND of all cells' force_valid
//   i_mu_done                    motion update finished (pulse or level)
//   o_start, o_mu_start          start to RL top / one-cycle motion update trigger
//   o_busy, o_done               not IDLE / one-cycle run-complete pulse
//   o_timeout_err                sticky watchdog error
//   o_iter_count, o_pass_cycles  completed passes / START..NEXT length of the last completed pass
module rl_run_controller #(
  parameter int NUM_CELLS         = 64,
  parameter int ITER_WIDTH        = 16,
  parameter int START_HOLD_CYCLES = 50,
  parameter int DRAIN_SETTLE      = 4,
  parameter int TIMEOUT_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES    = 2**20
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_go,
  input  logic                     i_abort,
  input  logic [ITER_WIDTH-1:0]    i_num_iterations,
  input  logic [NUM_CELLS-1:0]     i_reading_done,
  input  logic [NUM_CELLS-1:0]     i_back_pressure,
  input  logic [NUM_CELLS-1:0]     i_filter_buffer_empty,
  input  logic                     i_force_valid_and,
  input  logic                     i_mu_done,
  output logic                     o_start,
  output logic                     o_mu_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout_err,
  output logic [ITER_WIDTH-1:0]    o_iter_count,
  output logic [TIMEOUT_WIDTH-1:0] o_pass_cycles
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_READ_WAIT = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_MU        = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_ERROR     = 3'd7;

  localparam int HOLD_W   = $clog2(START_HOLD_CYCLES + 1);
  localparam int SETTLE_W = $clog2(DRAIN_SETTLE + 1);

  // Counters compare against "last" values so the exit decision is made in
  // the final cycle of the window and the new state starts exactly on time.
  localparam logic [HOLD_W-1:0]        HOLD_LAST   = HOLD_W'(START_HOLD_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]      SETTLE_LAST = SETTLE_W'(DRAIN_SETTLE - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST     = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [2:0]               r_state;
  logic [2:0]               w_nxt;
  logic [HOLD_W-1:0]        r_hold;
  logic [SETTLE_W-1:0]      r_settle;
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic [TIMEOUT_WIDTH-1:0] r_pcnt;
  logic [ITER_WIDTH-1:0]    r_target;
  logic [ITER_WIDTH-1:0]    r_iter;
  logic [TIMEOUT_WIDTH-1:0] r_pass_cycles;
  logic                     r_start;
  logic                     r_mu_start;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_terr;

  logic                     w_quiet;
  logic                     w_wait_state;
  logic [ITER_WIDTH-1:0]    w_iter_inc;

  assign w_quiet      = i_force_valid_and & (&i_filter_buffer_empty) & ~(|i_back_pressure);
  assign w_wait_state = (r_state == S_READ_WAIT) || (r_state == S_DRAIN) || (r_state == S_MU);
  assign w_iter_inc   = r_iter + ITER_WIDTH'(1);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:      if (i_go) w_nxt = S_START;
      S_START:     if (r_hold == HOLD_LAST) w_nxt = S_READ_WAIT;
      S_READ_WAIT: if (&i_reading_done) w_nxt = S_DRAIN;
      S_DRAIN:     if (w_quiet && (r_settle == SETTLE_LAST)) w_nxt = S_MU;
      S_MU:        if (i_mu_done) w_nxt = S_NEXT;
      S_NEXT:      w_nxt = (w_iter_inc == r_target) ? S_DONE : S_START;
      S_DONE:      w_nxt = S_IDLE;
      S_ERROR:     w_nxt = S_ERROR;
      default:     w_nxt = S_IDLE;
    endcase
    // Watchdog expiry beats the normal exit; abort beats everything.
    if (w_wait_state && (r_wd == WD_LAST)) w_nxt = S_ERROR;
    if (i_abort) w_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_settle      <= '0;
      r_wd          <= '0;
      r_pcnt        <= '0;
      r_target      <= '0;
      r_iter        <= '0;
      r_pass_cycles <= '0;
      r_start       <= 1'b0;
      r_mu_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_terr        <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_hold   <= ((r_state == S_START) && (w_nxt == S_START)) ? r_hold + HOLD_W'(1) : '0;
      r_settle <= ((r_state == S_DRAIN) && (w_nxt == S_DRAIN) && w_quiet)
                  ? r_settle + SETTLE_W'(1) : '0;
      r_wd     <= ((w_nxt == r_state) && w_wait_state) ? r_wd + TIMEOUT_WIDTH'(1) : '0;

      // Pass length counts the START entry cycle as 1 and saturates.
      if ((w_nxt == S_START) && (r_state != S_START)) begin
        r_pcnt <= TIMEOUT_WIDTH'(1);
      end else if (r_pcnt != {TIMEOUT_WIDTH{1'b1}}) begin
        r_pcnt <= r_pcnt + TIMEOUT_WIDTH'(1);
      end

      if ((r_state == S_IDLE) && (w_nxt == S_START)) begin
        r_target <= (i_num_iterations == '0) ? ITER_WIDTH'(1) : i_num_iterations;
        r_iter   <= '0;
      end else if ((r_state == S_NEXT) && !i_abort) begin
        r_iter        <= w_iter_inc;
        r_pass_cycles <= r_pcnt;
      end

      // Outputs follow the state being entered so they line up with it.
      r_start    <= (w_nxt == S_START);
      r_mu_start <= (w_nxt == S_MU) && (r_state != S_MU);
      r_busy     <= (w_nxt != S_IDLE);
      r_done     <= (w_nxt == S_DONE);
      r_terr     <= (w_nxt == S_ERROR);
    end
  end

  assign o_start       = r_start;
  assign o_mu_start    = r_mu_start;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout_err = r_terr;
  assign o_iter_count  = r_iter;
  assign o_pass_cycles = r_pass_cycles;

endmodule

// File: tb/tb_rl_run_controller.sv
// Purpose : drives whole runs against rl_run_controller and compares each cycle with a timeline model.
// Latency : the model predicts every event cycle (start window, mu_start, done) from the planned stimulus.
// Backpres: reading_done / quiet / mu_done timing is randomized per pass to exercise every wait state.
module tb_rl_run_controller;

  localparam int NC = 64;
  localparam int IW = 16;
  localparam int TW = 24;
  localparam int HOLD = 50;
  localparam int TMO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, go, abort, fva, mu_done;
  logic [IW-1:0] num_it;
  logic [NC-1:0] rd, bp, fbe;
  logic          start, mu_start, busy, done, terr;
  logic [IW-1:0] iter;
  logic [TW-1:0] pc;

  rl_run_controller #(
    .NUM_CELLS(NC), .ITER_WIDTH(IW), .START_HOLD_CYCLES(HOLD), .DRAIN_SETTLE(4),
    .TIMEOUT_WIDTH(TW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_abort(abort), .i_num_iterations(num_it),
    .i_reading_done(rd), .i_back_pressure(bp), .i_filter_buffer_empty(fbe),
    .i_force_valid_and(fva), .i_mu_done(mu_done),
    .o_start(start), .o_mu_start(mu_start), .o_busy(busy), .o_done(done),
    .o_timeout_err(terr), .o_iter_count(iter), .o_pass_cycles(pc)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int m_pc = 0;   // model: pass_cycles of last completed pass

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic check_ctl(input bit e_start, input bit e_mu, input bit e_busy,
                           input bit e_done, input bit e_terr);
    check("start", start, e_start);
    check("mu_start", mu_start, e_mu);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("timeout_err", terr, e_terr);
  endtask

  // Inputs for cycle N are driven just after posedge N; outputs sampled at the following negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [NC-1:0] partial_rd();
    logic [NC-1:0] v;
    int idx;
    for (int i = 0; i < NC; i++) v[i] = 1'($urandom_range(0, 1));
    idx = $urandom_range(0, NC - 1);
    v[idx] = 1'b0;
    return v;
  endfunction

  // mode 2 always breaks quiet via back_pressure[17]
  task automatic drive_quiet(input bit q, input int mode);
    int which;
    int idx;
    fva = 1'b1;
    fbe = '1;
    bp  = '0;
    if (!q) begin
      which = (mode == 2) ? 2 : $urandom_range(0, 2);
      idx   = (mode == 2) ? 17 : $urandom_range(0, NC - 1);
      case (which)
        0:       fva = 1'b0;
        1:       fbe[idx] = 1'b0;
        default: bp[idx] = 1'b1;
      endcase
    end
  endtask

  task automatic idle_inputs();
    go = 1'b0;
    abort = 1'b0;
    mu_done = 1'b0;
    rd = partial_rd();
    drive_quiet(1'($urandom_range(0, 1)), 0);
  endtask

  // One pass starting (START entry) at cycle ts. Called with cyc == ts-1.
  // mode 0 random, 1 fixed directed timing, 2 quiet broken after 3 quiet cycles.
  // stop_kind 1 asserts rst, 2 asserts abort, on the MU entry cycle.
  task automatic run_pass(input int ts, input int mode, input int k, input int stop_kind,
                          output int tn);
    int rd_at, d_at, m_at, mu_d, first;
    bit qarr[$];
    rd_at = ts + ((mode == 1) ? 80 : $urandom_range(10, 90));
    d_at  = (((ts + HOLD) > rd_at) ? (ts + HOLD) : rd_at) + 1;
    if (mode == 1) begin
      repeat (19) qarr.push_back(1'b0);
    end else if (mode == 2) begin
      repeat (3) qarr.push_back(1'b1);
      qarr.push_back(1'b0);
    end else begin
      repeat ($urandom_range(0, 12)) qarr.push_back(1'($urandom_range(0, 1)));
    end
    repeat (4) qarr.push_back(1'b1);
    first = -1;
    for (int j = 3; j < qarr.size(); j++)
      if (first < 0 && qarr[j] && qarr[j-1] && qarr[j-2] && qarr[j-3]) first = j;
    m_at = d_at + first + 1;
    mu_d = (mode == 1) ? 3 : $urandom_range(0, 5);
    tn   = m_at + mu_d + 1;
    while (cyc < tn) begin
      tick();
      rd = (cyc >= rd_at) ? '1 : partial_rd();
      if (cyc >= d_at && (cyc - d_at) < qarr.size()) drive_quiet(qarr[cyc - d_at], mode);
      else if (cyc >= d_at) drive_quiet(1'b1, mode);
      else drive_quiet(1'($urandom_range(0, 1)), mode);
      mu_done = (cyc == m_at + mu_d);
      go      = ($urandom_range(0, 7) == 0);
      num_it  = IW'($urandom);
      if (cyc == m_at && stop_kind == 1) rst = 1'b1;
      if (cyc == m_at && stop_kind == 2) abort = 1'b1;
      sample();
      check_ctl(cyc <= ts + HOLD - 1, cyc == m_at, 1'b1, 1'b0, 1'b0);
      check("iter_count", iter, k);
      check("pass_cycles", pc, m_pc);
      if (cyc == m_at && stop_kind != 0) return;
    end
  endtask

  task automatic run_job(input int n, input int mode, input int stop_pass, input int stop_kind);
    int target, ts, tn;
    tick();
    idle_inputs();
    go = 1'b1;
    num_it = IW'(n);
    sample();
    check("idle_busy", busy, 0);
    target = (n == 0) ? 1 : n;
    ts = cyc + 1;
    for (int p = 0; p < target; p++) begin
      run_pass(ts, mode, p, (p == stop_pass) ? stop_kind : 0, tn);
      if (p == stop_pass) begin
        tick();
        rst = 1'b0;
        idle_inputs();
        sample();
        if (stop_kind == 1) m_pc = 0;
        check_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stop_iter", iter, (stop_kind == 1) ? 0 : p);
        check("stop_pass_cycles", pc, m_pc);
        tick();
        idle_inputs();
        sample();
        check("stop_no_done", done, 0);
        check("stop_idle", busy, 0);
        return;
      end
      m_pc = tn - ts + 1;
      ts = tn + 1;
    end
    tick();                       // DONE: a go here must be ignored
    idle_inputs();
    go = 1'($urandom_range(0, 1));
    sample();
    check_ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("final_iter", iter, target);
    check("final_pass_cycles", pc, m_pc);
    tick();
    idle_inputs();
    sample();
    check_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_iter", iter, target);
  endtask

  task automatic run_timeout();
    int ts;
    tick();
    idle_inputs();
    go = 1'b1;
    num_it = 1;
    sample();
    ts = cyc + 1;
    repeat (160) begin
      tick();
      idle_inputs();
      rd[NC-1] = 1'b0;
      go = ($urandom_range(0, 7) == 0);
      mu_done = 1'($urandom_range(0, 1));
      sample();
      check_ctl(cyc <= ts + HOLD - 1, 1'b0, 1'b1, 1'b0, cyc >= ts + HOLD + TMO);
      check("tmo_iter", iter, 0);
      check("tmo_pass_cycles", pc, m_pc);
    end
    tick();
    idle_inputs();
    rd[NC-1] = 1'b0;
    abort = 1'b1;
    sample();
    check("tmo_sticky", terr, 1);
    tick();
    idle_inputs();
    sample();
    check_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tmo_abort_iter", iter, 0);
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    abort = 1'b0;
    num_it = '0;
    rd = '0;
    bp = '0;
    fbe = '0;
    fva = 1'b0;
    mu_done = 1'b0;
    repeat (3) tick();
    sample();
    check_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_iter", iter, 0);
    check("reset_pass_cycles", pc, 0);
    tick();
    rst = 1'b0;
    idle_inputs();
    sample();

    run_job(1, 1, -1, 0);          // directed single pass
    run_job(3, 0, -1, 0);          // three passes
    run_job(2, 2, -1, 0);          // settle restart on back_pressure[17]
    run_timeout();                 // reading_done[63] stuck low
    run_job(5, 0, 2, 1);           // rst in MU at iter_count 2
    run_job(2, 0, -1, 0);          // restart counts from 0
    run_job(0, 0, -1, 0);          // zero iterations -> one pass
    run_job(3, 0, 1, 2);           // abort in MU keeps iter_count
    repeat (6) run_job($urandom_range(0, 4), 0, -1, 0);

    tick();                        // go and abort together in IDLE
    idle_inputs();
    go = 1'b1;
    abort = 1'b1;
    sample();
    tick();
    idle_inputs();
    sample();
    check("go_abort_busy", busy, 0);
    check("go_abort_start", start, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
